// File: rtl/vram_arbiter.sv
// vram_arbiter: shares a single-port 2bpp 320x240 framebuffer RAM between display scanout and game logic.
// Optional VRAM_ARB_RANGE_GUARD_EN: out-of-range accesses are neutralised at the RAM pins and read back as 2'b00.
module vram_arbiter #(
    parameter int ADDR_W   = 19,
    parameter int FB_WORDS = 76800,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [1:0]        disp_rdata,
    input  logic              game_req,
    input  logic              game_we,
    input  logic [ADDR_W-1:0] game_addr,
    input  logic [1:0]        game_wdata,
    output logic              game_gnt,
    output logic              game_rvalid,
    output logic [1:0]        game_rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_write_enabled,
    output logic [1:0]        ram_write_data,
    input  logic [1:0]        ram_read_data
);

`ifdef VRAM_ARB_RANGE_GUARD_EN
    localparam logic GUARD_EN = 1'b1;
`else
    localparam logic GUARD_EN = 1'b0;
`endif
    localparam logic [3:0]      WAIT_LIMIT = 4'(MAX_WAIT);
    localparam logic [ADDR_W:0] FB_LIMIT   = (ADDR_W + 1)'(FB_WORDS);

    typedef enum logic {DISP_PRI = 1'b0, GAME_PRI = 1'b1} pri_t;

    pri_t              state;
    logic [3:0]        wait_cnt;
    logic [2:0]        tag_pipe [RD_LAT];
    logic [2:0]        tag_in;
    logic [2:0]        tag_out;
    logic [ADDR_W-1:0] sel_addr;
    logic              out_of_range;
    logic              game_read;
    logic [1:0]        ret_data;
    logic [1:0]        disp_hold;
    logic [1:0]        game_hold;

    // Grant decision from current requests and the registered priority state.
    always_comb begin
        disp_gnt = 1'b0;
        game_gnt = 1'b0;
        if (reset) begin
            disp_gnt = 1'b0;
            game_gnt = 1'b0;
        end else if (state == GAME_PRI) begin
            game_gnt = game_req;
            disp_gnt = disp_req & ~game_req;
        end else begin
            disp_gnt = disp_req;
            game_gnt = game_req & ~disp_req;
        end
    end

    // RAM pin drive follows the winner; idle pins sit at zero.
    always_comb begin
        sel_addr = '0;
        if (disp_gnt) begin
            sel_addr = disp_addr;
        end else if (game_gnt) begin
            sel_addr = game_addr;
        end else begin
            sel_addr = '0;
        end
        out_of_range      = GUARD_EN & (disp_gnt | game_gnt) & ({1'b0, sel_addr} >= FB_LIMIT);
        ram_address       = out_of_range ? '0 : sel_addr;
        ram_write_enabled = game_gnt & game_we & ~out_of_range;
        ram_write_data    = game_gnt ? game_wdata : 2'b00;
    end

    // Tag bits: {display read, game read, forced-zero data}.
    assign game_read = game_gnt & ~game_we;
    assign tag_in    = {disp_gnt, game_read, out_of_range & (disp_gnt | game_read)};
    assign tag_out   = tag_pipe[RD_LAT-1];
    assign ret_data  = tag_out[0] ? 2'b00 : ram_read_data;

    // Priority state and starvation counter; GAME_PRI is entered on the edge the counter reaches its limit.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= DISP_PRI;
            wait_cnt <= 4'd0;
        end else begin
            if (game_gnt || !game_req) begin
                wait_cnt <= 4'd0;
            end else if (wait_cnt < WAIT_LIMIT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end else begin
                wait_cnt <= wait_cnt;
            end
            case (state)
                DISP_PRI: begin
                    if (game_req && !game_gnt && ((wait_cnt + 4'd1) >= WAIT_LIMIT)) begin
                        state <= GAME_PRI;
                    end else begin
                        state <= DISP_PRI;
                    end
                end
                GAME_PRI: begin
                    if (game_gnt || !game_req) begin
                        state <= DISP_PRI;
                    end else begin
                        state <= GAME_PRI;
                    end
                end
                default: state <= DISP_PRI;
            endcase
        end
    end

    // Read tag pipeline, aligned with the RAM read latency.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                tag_pipe[i] <= 3'b000;
            end
        end else begin
            tag_pipe[0] <= tag_in;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    // Last delivered data per requester, shown while its rvalid is low.
    always_ff @(posedge clock) begin
        if (reset) begin
            disp_hold <= 2'b00;
            game_hold <= 2'b00;
        end else begin
            if (tag_out[2]) begin
                disp_hold <= ret_data;
            end else begin
                disp_hold <= disp_hold;
            end
            if (tag_out[1]) begin
                game_hold <= ret_data;
            end else begin
                game_hold <= game_hold;
            end
        end
    end

    assign disp_rvalid = ~reset & tag_out[2];
    assign game_rvalid = ~reset & tag_out[1];
    assign disp_rdata  = reset ? 2'b00 : (tag_out[2] ? ret_data : disp_hold);
    assign game_rdata  = reset ? 2'b00 : (tag_out[1] ? ret_data : game_hold);

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed and random stimulus against a queue-based reference model of vram_arbiter (RD_LAT=2).
// Covers the VRAM_ARB_RANGE_GUARD_EN feature when the macro is defined for both files.
module tb_vram_arbiter;
    localparam int AW  = 19;
    localparam int FB  = 76800;
    localparam int RDL = 2;
    localparam int MW  = 4;
`ifdef VRAM_ARB_RANGE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          disp_req, game_req, game_we;
    logic [AW-1:0] disp_addr, game_addr;
    logic [1:0]    game_wdata;
    logic          disp_gnt, disp_rvalid, game_gnt, game_rvalid, ram_write_enabled;
    logic [1:0]    disp_rdata, game_rdata, ram_write_data, ram_read_data;
    logic [AW-1:0] ram_address;

    vram_arbiter #(.ADDR_W(AW), .FB_WORDS(FB), .RD_LAT(RDL), .MAX_WAIT(MW)) dut (
        .clock(clock), .reset(reset),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
        .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
        .game_req(game_req), .game_we(game_we), .game_addr(game_addr), .game_wdata(game_wdata),
        .game_gnt(game_gnt), .game_rvalid(game_rvalid), .game_rdata(game_rdata),
        .ram_address(ram_address), .ram_write_enabled(ram_write_enabled),
        .ram_write_data(ram_write_data), .ram_read_data(ram_read_data)
    );

    always #5 clock = ~clock;

    // Framebuffer RAM environment: read latency RDL, unwritten words read as zero.
    logic [1:0] ram_mem [int];
    logic [1:0] rd_pipe [RDL];
    always @(posedge clock) begin
        rd_pipe[0] <= ram_mem.exists(int'(ram_address)) ? ram_mem[int'(ram_address)] : 2'b00;
        for (int i = 1; i < RDL; i++) rd_pipe[i] <= rd_pipe[i-1];
        if (ram_write_enabled) ram_mem[int'(ram_address)] = ram_write_data;
    end
    assign ram_read_data = rd_pipe[RDL-1];

    typedef struct {
        int         due;
        bit         is_disp;
        logic [1:0] data;
    } ret_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         waited = 0;
    logic [1:0] ref_mem [int];
    ret_t       retq [$];
    logic [1:0] exp_dh = 2'b00;
    logic [1:0] exp_gh = 2'b00;
    bit         last_gd = 1'b0;
    bit         last_gg = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit oob(input logic [AW-1:0] a);
        return GUARD && (int'(a) >= FB);
    endfunction

    function automatic logic [1:0] ref_read(input logic [AW-1:0] a);
        if (oob(a)) return 2'b00;
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 2'b00;
    endfunction

    function automatic logic [AW-1:0] pick_addr();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return AW'(FB - 1);
        if (r == 1) return AW'(38420);
        return AW'($urandom_range(0, 7));
    endfunction

    // One clock: compare every output to the model mid-cycle, then advance the model at the edge.
    task automatic tick();
        bit            eg_d, eg_g, erv_d, erv_g, ewe;
        logic [AW-1:0] ea;
        logic [1:0]    ewd, erd_d, erd_g;
        #4;
        eg_d = 1'b0; eg_g = 1'b0; erv_d = 1'b0; erv_g = 1'b0; ewe = 1'b0;
        ea = '0; ewd = 2'b00; erd_d = 2'b00; erd_g = 2'b00;
        if (!reset) begin
            eg_g = game_req && (!disp_req || waited >= MW);
            eg_d = disp_req && !eg_g;
            if (eg_d) ea = disp_addr;
            else if (eg_g) ea = game_addr;
            if ((eg_d || eg_g) && oob(ea)) ea = '0;
            ewe = eg_g && game_we && !oob(game_addr);
            ewd = eg_g ? game_wdata : 2'b00;
            if (retq.size() > 0 && retq[0].due == cyc) begin
                erv_d = retq[0].is_disp;
                erv_g = !retq[0].is_disp;
            end
            erd_d = erv_d ? retq[0].data : exp_dh;
            erd_g = erv_g ? retq[0].data : exp_gh;
        end
        chk("disp_gnt", 32'(disp_gnt), 32'(eg_d));
        chk("game_gnt", 32'(game_gnt), 32'(eg_g));
        chk("ram_address", 32'(ram_address), 32'(ea));
        chk("ram_we", 32'(ram_write_enabled), 32'(ewe));
        chk("ram_wdata", 32'(ram_write_data), 32'(ewd));
        chk("disp_rvalid", 32'(disp_rvalid), 32'(erv_d));
        chk("game_rvalid", 32'(game_rvalid), 32'(erv_g));
        chk("disp_rdata", 32'(disp_rdata), 32'(erd_d));
        chk("game_rdata", 32'(game_rdata), 32'(erd_g));
        last_gd = eg_d;
        last_gg = eg_g;
        @(posedge clock);
        if (reset) begin
            waited = 0;
            retq.delete();
            exp_dh = 2'b00;
            exp_gh = 2'b00;
        end else begin
            if (erv_d) exp_dh = erd_d;
            if (erv_g) exp_gh = erd_g;
            if (erv_d || erv_g) void'(retq.pop_front());
            if (eg_d) retq.push_back('{cyc + RDL, 1'b1, ref_read(disp_addr)});
            if (eg_g && !game_we) retq.push_back('{cyc + RDL, 1'b0, ref_read(game_addr)});
            if (eg_g && game_we && !oob(game_addr)) ref_mem[int'(game_addr)] = game_wdata;
            waited = (game_req && !eg_g) ? waited + 1 : 0;
        end
        cyc++;
        #1;
    endtask

    initial begin
        reset = 1'b1; disp_req = 1'b0; game_req = 1'b0; game_we = 1'b0;
        disp_addr = '0; game_addr = '0; game_wdata = 2'b00;
        @(posedge clock);
        #1;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Game write then read-back of 38420.
        game_req = 1'b1; game_we = 1'b1; game_addr = AW'(38420); game_wdata = 2'b01;
        #1;
        chk("d1_gnt", 32'(game_gnt), 32'd1);
        chk("d1_we", 32'(ram_write_enabled), 32'd1);
        chk("d1_addr", 32'(ram_address), 32'd38420);
        tick();
        game_we = 1'b0;
        tick();
        game_req = 1'b0;
        tick();
        #1;
        chk("d1_rvalid", 32'(game_rvalid), 32'd1);
        chk("d1_rdata", 32'(game_rdata), 32'd1);
        tick();

        // Back-to-back game writes to 0..9.
        game_req = 1'b1; game_we = 1'b1;
        for (int a = 0; a < 10; a++) begin
            game_addr = AW'(a);
            game_wdata = 2'(a);
            #1;
            chk("b2b_game_gnt", 32'(game_gnt), 32'd1);
            chk("b2b_disp_gnt", 32'(disp_gnt), 32'd0);
            tick();
        end
        game_req = 1'b0;
        tick();

        // Both requesting continuously: game wins every fifth cycle.
        disp_req = 1'b1; disp_addr = AW'(5);
        game_req = 1'b1; game_we = 1'b1; game_addr = AW'(7); game_wdata = 2'b10;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("fair_game_gnt", 32'(game_gnt), (i == 4 || i == 9) ? 32'd1 : 32'd0);
            tick();
        end
        disp_req = 1'b0; game_req = 1'b0;
        repeat (3) tick();

        // Interleaved display/game reads never cross-deliver.
        game_req = 1'b1; game_we = 1'b1; game_addr = AW'(0); game_wdata = 2'b11;
        tick();
        game_addr = AW'(319); game_wdata = 2'b10;
        tick();
        game_req = 1'b0; disp_req = 1'b1; disp_addr = AW'(0);
        tick();
        disp_req = 1'b0; game_req = 1'b1; game_we = 1'b0; game_addr = AW'(319);
        tick();
        game_req = 1'b0;
        #1;
        chk("il_disp_rvalid", 32'(disp_rvalid), 32'd1);
        chk("il_disp_rdata", 32'(disp_rdata), 32'd3);
        chk("il_game_rvalid0", 32'(game_rvalid), 32'd0);
        tick();
        #1;
        chk("il_game_rvalid", 32'(game_rvalid), 32'd1);
        chk("il_game_rdata", 32'(game_rdata), 32'd2);
        chk("il_disp_rvalid0", 32'(disp_rvalid), 32'd0);
        tick();

        // Reset one cycle after a display read grant discards the read.
        disp_req = 1'b1; disp_addr = AW'(319);
        tick();
        reset = 1'b1; game_req = 1'b1; game_we = 1'b1; game_addr = AW'(3);
        #1;
        chk("rst_disp_gnt", 32'(disp_gnt), 32'd0);
        chk("rst_game_gnt", 32'(game_gnt), 32'd0);
        chk("rst_we", 32'(ram_write_enabled), 32'd0);
        chk("rst_disp_rvalid", 32'(disp_rvalid), 32'd0);
        chk("rst_disp_rdata", 32'(disp_rdata), 32'd0);
        chk("rst_game_rdata", 32'(game_rdata), 32'd0);
        tick();
        tick();
        reset = 1'b0; disp_req = 1'b0; game_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("post_rst_rvalid", 32'(disp_rvalid), 32'd0);
            tick();
        end

`ifdef VRAM_ARB_RANGE_GUARD_EN
        game_req = 1'b1; game_we = 1'b1; game_addr = AW'(76800); game_wdata = 2'b11;
        #1;
        chk("guard_gnt", 32'(game_gnt), 32'd1);
        chk("guard_we", 32'(ram_write_enabled), 32'd0);
        tick();
        game_we = 1'b0; game_addr = AW'(76801);
        tick();
        game_req = 1'b0;
        tick();
        #1;
        chk("guard_rvalid", 32'(game_rvalid), 32'd1);
        chk("guard_rdata", 32'(game_rdata), 32'd0);
        tick();
`endif

        // Random traffic; each requester holds its request until granted.
        for (int i = 0; i < 400; i++) begin
            if (!disp_req || last_gd) begin
                disp_req = ($urandom_range(0, 3) != 0);
                disp_addr = pick_addr();
            end
            if (!game_req || last_gg) begin
                game_req = ($urandom_range(0, 3) != 0);
                game_we = ($urandom_range(0, 1) != 0);
                game_addr = pick_addr();
                game_wdata = 2'($urandom_range(0, 3));
            end
            tick();
        end
        disp_req = 1'b0; game_req = 1'b0;
        repeat (4) tick();
        chk("drain_empty", 32'(retq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port 2-bit-per-pixel 320x240 framebuffer RAM between two requesters: display scanout (read-only) and game logic (read/write).
- Display has default priority; an aging counter guarantees game logic forward progress.
- Sits between the game logic, the VGA pixel fetcher and the framebuffer RAM; owns the RAM's address, write-enable and write-data pins.
- Tags in-flight reads so each requester gets back only its own data.

Parameters:
- ADDR_W, 19, framebuffer word address width
- FB_WORDS, 76800, number of valid framebuffer words (320*240)
- RD_LAT, 1, RAM read latency in clocks (1..4)
- MAX_WAIT, 4, consecutive denied game cycles before game gets forced priority (1..15)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- disp_req  in  1  display read request
- disp_addr  in  ADDR_W  display read address
- disp_gnt  out  1  display request accepted this cycle
- disp_rvalid  out  1  display read data valid
- disp_rdata  out  2  display read data
- game_req  in  1  game access request
- game_we  in  1  1 = write, 0 = read
- game_addr  in  ADDR_W  game address
- game_wdata  in  2  game write data
- game_gnt  out  1  game request accepted this cycle
- game_rvalid  out  1  game read data valid
- game_rdata  out  2  game read data
- ram_address  out  ADDR_W  to RAM
- ram_write_enabled  out  1  to RAM
- ram_write_data  out  2  to RAM
- ram_read_data  in  2  from RAM, RD_LAT clocks after address

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Arbitration and handshake:
  - Decision is combinational from the current req inputs and the registered priority state.
  - At most one gnt is high per cycle.
  - A requester holds req, addr, we and wdata stable until it sees gnt high on a rising edge.
  - Grant completes the transfer; a requester may issue back-to-back (one per cycle).
- Priority state machine (registered):
  - DISP_PRI (reset state): display wins if disp_req; otherwise game wins if game_req.
  - GAME_PRI: game wins if game_req; otherwise display wins.
  - DISP_PRI -> GAME_PRI when wait_cnt reaches MAX_WAIT.
  - GAME_PRI -> DISP_PRI on the cycle after a game grant, or when game_req drops.
- wait_cnt (4 bits):
  - Increments on each cycle with game_req=1 and game_gnt=0.
  - Clears on game_gnt or game_req=0.
  - Saturates at MAX_WAIT.
- RAM drive (combinational from the grant):
  - ram_address = granted addr.
  - ram_write_enabled = game_gnt & game_we.
  - ram_write_data = game_wdata.
  - With no grant: ram_address = 0, ram_write_enabled = 0, ram_write_data = 0.
- Read return:
  - An RD_LAT-deep shift register of 2-bit tags {disp_rd, game_rd} records each granted read.
  - When the tag exits the shift register: the matching rvalid pulses for 1 cycle, and its rdata = ram_read_data.
  - rdata holds its last value when rvalid is low.
  - Writes enter no tag and produce no rvalid.
- Ordering: returns are in grant order; latency from grant to rvalid is exactly RD_LAT clocks.
- Same-address hazard: a game write granted at cycle N is visible to any read granted at N+1 or later. Reads granted in the same cycle as the write cannot occur.
- Reset values:
  - disp_gnt, game_gnt, disp_rvalid, game_rvalid = 0.
  - disp_rdata, game_rdata = 0.
  - state = DISP_PRI, wait_cnt = 0, tag pipeline cleared.
- Reset mid-operation: in-flight reads are discarded, with no rvalid after reset. Reset held high forces both gnts to 0 and ram_write_enabled to 0.
- Simultaneous requests with wait_cnt below MAX_WAIT: the display is granted.
- Idle (no req): the RAM is driven to the idle values; no state change beyond wait_cnt clearing.

Optional Feature:
- Macro: VRAM_ARB_RANGE_GUARD_EN.
- Defined:
  - Any granted access with addr >= FB_WORDS is still granted (no deadlock).
  - For such an access, ram_write_enabled is forced to 0 and ram_address is forced to 0.
  - A read of that kind still returns rvalid after RD_LAT, with rdata = 2'b00.
- Undefined:
  - Addresses pass through unchecked.
  - Out-of-range behaviour is whatever the RAM does.

Test Plan:
- Game write addr 38420 data 2'b01 with disp_req=0 -> game_gnt same cycle, ram_write_enabled=1, ram_address=38420; a following game read of 38420 -> game_rvalid after RD_LAT with game_rdata=2'b01.
- disp_req and game_req held high continuously, MAX_WAIT=4 -> display granted 4 cycles, game granted on the 5th, then display again; the pattern repeats and no game request waits more than 5 cycles.
- Interleaved grants: display read addr 0 (RAM returns 2'b11), then game read addr 319 (returns 2'b10) -> disp_rvalid with 2'b11 at grant+RD_LAT, game_rvalid with 2'b10 one cycle later, never cross-delivered.
- Reset asserted one cycle after a display read grant with RD_LAT=2 -> no disp_rvalid ever appears; all outputs are 0 while reset is high.
- With VRAM_ARB_RANGE_GUARD_EN defined: game write to addr 76800 -> game_gnt=1, ram_write_enabled=0; game read to 76801 -> game_rvalid with game_rdata=2'b00.
- Game req only, continuous writes to addr 0..9 -> 10 consecutive grants, one per clock, and disp_gnt stays 0.
